// File: rtl/gbc_dma_pkg.sv
// Shared types and default constants for the OAM block-copy DMA arbiter.
package gbc_dma_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite
  } dma_state_e;

  localparam int unsigned DefLen     = 160;
  localparam logic [15:0] DefDst     = 16'hFE00;
  localparam logic [15:0] DefRegAddr = 16'hFF46;

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// CPU-side and memory-side bus of the DMA arbiter.
// master: the arbiter itself; slave: the CPU and memory it sits between.
interface oam_dma_arbiter_if;

  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait;

  logic [15:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport master (
    input  cpu_addr, cpu_we, cpu_re, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_wait, mem_addr, mem_we, mem_re, mem_wdata
  );

  modport slave (
    output cpu_addr, cpu_we, cpu_re, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_wait, mem_addr, mem_we, mem_re, mem_wdata
  );

endinterface

// File: rtl/oam_dma_seq.sv
// Block-copy sequencer: read source byte, write destination byte, LEN times.
// OAM_DMA_RESTART_EN: a trigger while busy restarts the copy from the new page.
module oam_dma_seq
  import gbc_dma_pkg::*;
#(
  parameter int unsigned LEN = DefLen,
  parameter logic [15:0] DST = DefDst
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trig,
  input  logic [7:0]  trig_page,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic [7:0]  page,
  output logic [15:0] dma_addr,
  output logic        dma_we,
  output logic        dma_re,
  output logic [7:0]  dma_wdata
);

  localparam logic [8:0] LastIdx = 9'(LEN - 1);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] buf_q, buf_d;
  logic [8:0] cnt_q, cnt_d;
  logic       trig_ok;

`ifdef OAM_DMA_RESTART_EN
  assign trig_ok = trig;
`else
  assign trig_ok = trig && (state_q == StIdle);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      page_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    dma_addr  = '0;
    dma_we    = 1'b0;
    dma_re    = 1'b0;
    dma_wdata = '0;
    unique case (state_q)
      StIdle: ;
      StRead: begin
        dma_addr = {page_q, cnt_q[7:0]};
        dma_re   = 1'b1;
        buf_d    = mem_rdata;
        state_d  = StWrite;
      end
      StWrite: begin
        // 16-bit sum wraps past FFFF by construction
        dma_addr  = DST + {7'b0, cnt_q};
        dma_we    = 1'b1;
        dma_wdata = buf_q;
        if (cnt_q == LastIdx) begin
          state_d = StIdle;
        end else begin
          cnt_d   = cnt_q + 9'd1;
          state_d = StRead;
        end
      end
      default: state_d = StIdle;
    endcase
    if (trig_ok) begin
      page_d  = trig_page;
      cnt_d   = '0;
      state_d = StRead;
    end
  end

  assign busy = (state_q != StIdle);
  assign page = page_q;

endmodule

// File: rtl/oam_dma_arbiter.sv
// Shares a single-port byte memory between the CPU and the OAM block-copy DMA.
// Build option OAM_DMA_RESTART_EN (see oam_dma_seq) controls re-trigger while busy.
module oam_dma_arbiter
  import gbc_dma_pkg::*;
#(
  parameter int unsigned LEN      = DefLen,
  parameter logic [15:0] DST      = DefDst,
  parameter logic [15:0] REG_ADDR = DefRegAddr
) (
  input  logic                      clock,
  input  logic                      reset,
  oam_dma_arbiter_if.master         bus,
  output logic                      dma_busy
);

  logic        reg_hit;
  logic [7:0]  page;
  logic [15:0] dma_addr;
  logic        dma_we;
  logic        dma_re;
  logic [7:0]  dma_wdata;

  assign reg_hit = (bus.cpu_addr == REG_ADDR);

  oam_dma_seq #(
    .LEN (LEN),
    .DST (DST)
  ) u_seq (
    .clock     (clock),
    .reset     (reset),
    .trig      (reg_hit && bus.cpu_we),
    .trig_page (bus.cpu_wdata),
    .mem_rdata (bus.mem_rdata),
    .busy      (dma_busy),
    .page      (page),
    .dma_addr  (dma_addr),
    .dma_we    (dma_we),
    .dma_re    (dma_re),
    .dma_wdata (dma_wdata)
  );

  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_wdata = '0;
    bus.cpu_rdata = '0;
    bus.cpu_wait  = 1'b0;

    // Memory side: DMA owns the bus while busy; register accesses never reach memory.
    if (dma_busy) begin
      bus.mem_addr  = dma_addr;
      bus.mem_we    = dma_we;
      bus.mem_re    = dma_re;
      bus.mem_wdata = dma_wdata;
    end else if (!reg_hit) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_re    = bus.cpu_re;
      bus.mem_wdata = bus.cpu_we ? bus.cpu_wdata : 8'h00;
    end

    // CPU side: register is always serviced; memory accesses stall while busy.
    if (reg_hit) begin
      bus.cpu_rdata = bus.cpu_re ? page : 8'h00;
    end else if (dma_busy) begin
      bus.cpu_wait = bus.cpu_we || bus.cpu_re;
    end else begin
      bus.cpu_rdata = bus.cpu_re ? bus.mem_rdata : 8'h00;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed + randomized bench for oam_dma_arbiter against a byte-array copy model.
module tb_oam_dma_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dma_busy;
  logic dma_busy1;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] mem  [65536];
  logic [7:0] mem1 [65536];
  logic [7:0] ref_mem [65536];

  always #5 clock = ~clock;

  oam_dma_arbiter_if bus ();
  oam_dma_arbiter_if bus1 ();

  oam_dma_arbiter #(
    .LEN      (160),
    .DST      (16'hFE00),
    .REG_ADDR (16'hFF46)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .dma_busy (dma_busy)
  );

  oam_dma_arbiter #(
    .LEN      (1),
    .DST      (16'hFFFF),
    .REG_ADDR (16'hFF46)
  ) dut1 (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus1),
    .dma_busy (dma_busy1)
  );

  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus1.mem_rdata = mem1[bus1.mem_addr];

  always @(posedge clock) begin
    if (bus.mem_we)  mem[bus.mem_addr]   <= bus.mem_wdata;
    if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All bus tasks are entered just after a negedge and return just after a later negedge.
  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.cpu_addr = a; bus.cpu_we = 1'b1; bus.cpu_re = 1'b0; bus.cpu_wdata = d;
    if (a != 16'hFF46) ref_mem[a] = d;
    @(negedge clock);
    bus.cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] v);
    bus.cpu_addr = a; bus.cpu_we = 1'b0; bus.cpu_re = 1'b1;
    #1 v = bus.cpu_rdata;
    @(negedge clock);
    bus.cpu_re = 1'b0;
  endtask

  task automatic wr1(input logic [15:0] a, input logic [7:0] d);
    bus1.cpu_addr = a; bus1.cpu_we = 1'b1; bus1.cpu_re = 1'b0; bus1.cpu_wdata = d;
    @(negedge clock);
    bus1.cpu_we = 1'b0;
  endtask

  task automatic model_copy(input logic [7:0] pg, input int n, input logic [15:0] dst);
    for (int i = 0; i < n; i++) ref_mem[dst + 16'(i)] = ref_mem[{pg, 8'(i)}];
  endtask

  task automatic check_region(input string tag, input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      a = base + 16'(i);
      check($sformatf("%s@%h", tag, a), {24'h0, mem[a]}, {24'h0, ref_mem[a]});
    end
  endtask

  task automatic fill_dst();
    for (int i = 0; i <= 160; i++) wr(16'hFE00 + 16'(i), 8'hEE);
  endtask

  task automatic measure(output int n);
    n = 0;
    while (dma_busy && n < 2000) begin
      n++;
      @(negedge clock);
    end
  endtask

  initial begin
    logic [7:0]  v;
    logic [7:0]  pg;
    logic [7:0]  b1;
    logic [15:0] a;
    int          cycles;
    int          stall_bad;
    int          exp_cycles;
    logic [7:0]  exp_page;

    bus.cpu_addr = '0; bus.cpu_we = 1'b0; bus.cpu_re = 1'b0; bus.cpu_wdata = '0;
    bus1.cpu_addr = '0; bus1.cpu_we = 1'b0; bus1.cpu_re = 1'b0; bus1.cpu_wdata = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state
    #1;
    check("rst_wait", bus.cpu_wait, 0);
    check("rst_busy", dma_busy, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_re", bus.mem_re, 0);
    check("rst_rdata", bus.cpu_rdata, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    @(negedge clock);
    rd(16'hFF46, v);
    check("rst_page", v, 8'h00);

    // Idle passthrough
    bus.cpu_addr = 16'hC000; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'hA5;
    #1;
    check("pt_mem_we", bus.mem_we, 1);
    check("pt_mem_addr", bus.mem_addr, 16'hC000);
    check("pt_mem_wdata", bus.mem_wdata, 8'hA5);
    check("pt_wr_wait", bus.cpu_wait, 0);
    @(negedge clock);
    bus.cpu_we = 1'b0; bus.cpu_re = 1'b1;
    #1;
    check("pt_mem_re", bus.mem_re, 1);
    check("pt_rd_data", bus.cpu_rdata, 8'hA5);
    check("pt_rd_wait", bus.cpu_wait, 0);
    @(negedge clock);
    bus.cpu_re = 1'b0;

    // Randomized passthrough traffic over a small address window
    for (int i = 0; i < 8; i++) wr(16'hC100 + 16'(i), 8'($urandom));
    for (int i = 0; i < 32; i++) begin
      a = 16'hC100 + 16'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) wr(a, 8'($urandom));
      else begin
        rd(a, v);
        check($sformatf("pt_rand@%h", a), v, ref_mem[a]);
      end
    end

    // Full copy from page C0 with a CPU read stalled 5 cycles in
    for (int i = 0; i < 160; i++) wr(16'hC000 + 16'(i), 8'(i) ^ 8'h5A);
    fill_dst();
    bus.cpu_addr = 16'hFF46; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'hC0;
    #1;
    check("trig_wait", bus.cpu_wait, 0);
    check("trig_no_fwd", bus.mem_we, 0);
    @(negedge clock);
    bus.cpu_we = 1'b0;
    #1;
    check("first_rd_re", bus.mem_re, 1);
    check("first_rd_addr", bus.mem_addr, 16'hC000);
    cycles = 0; stall_bad = 0;
    while (dma_busy && cycles < 2000) begin
      cycles++;
      if (cycles == 6) begin
        bus.cpu_addr = 16'hC010; bus.cpu_re = 1'b1;
        #1;
      end
      if (bus.cpu_re && (bus.cpu_wait !== 1'b1 || bus.cpu_rdata !== 8'h00)) stall_bad++;
      @(negedge clock);
      #1;
    end
    check("copy_busy_cycles", cycles, 320);
    check("stall_held", stall_bad, 0);
    check("stall_release_wait", bus.cpu_wait, 0);
    check("stall_release_data", bus.cpu_rdata, ref_mem[16'hC010]);
    @(negedge clock);
    bus.cpu_re = 1'b0;
    model_copy(8'hC0, 160, 16'hFE00);
    check_region("copy", 16'hFE00, 161);
    rd(16'hFF46, v);
    check("page_rb", v, 8'hC0);

    // Copy from a random page with random contents
    pg = 8'hC1 + 8'($urandom_range(0, 14));
    for (int i = 0; i < 160; i++) wr({pg, 8'(i)}, 8'($urandom));
    fill_dst();
    wr(16'hFF46, pg);
    measure(cycles);
    check("rand_busy_cycles", cycles, 320);
    model_copy(pg, 160, 16'hFE00);
    check_region("rand_copy", 16'hFE00, 161);

    // Reset during the read of byte 40
    fill_dst();
    wr(16'hFF46, 8'hC0);
    repeat (80) @(negedge clock);
    #1;
    check("byte40_addr", bus.mem_addr, 16'hC028);
    check("byte40_re", bus.mem_re, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_busy", dma_busy, 0);
    check("midrst_wait", bus.cpu_wait, 0);
    check("midrst_mem_we", bus.mem_we, 0);
    check("midrst_mem_re", bus.mem_re, 0);
    check("midrst_wdata", bus.mem_wdata, 0);
    @(negedge clock);
    model_copy(8'hC0, 40, 16'hFE00);
    check_region("midrst", 16'hFE00, 161);
    rd(16'hFF46, v);
    check("midrst_page", v, 8'h00);

    // Re-trigger with page D0 while byte 9 is being written
    for (int i = 0; i < 160; i++) wr({8'hD0, 8'(i)}, 8'($urandom));
    fill_dst();
    wr(16'hFF46, 8'hC0);
    cycles = 0;
    while (dma_busy && cycles < 2000) begin
      cycles++;
      if (cycles == 20) begin
        bus.cpu_addr = 16'hFF46; bus.cpu_we = 1'b1; bus.cpu_wdata = 8'hD0;
        #1;
        check("retrig_wait", bus.cpu_wait, 0);
      end
      @(negedge clock);
      bus.cpu_we = 1'b0;
    end
`ifdef OAM_DMA_RESTART_EN
    exp_cycles = 340;
    exp_page   = 8'hD0;
    model_copy(8'hC0, 10, 16'hFE00);
    model_copy(8'hD0, 160, 16'hFE00);
`else
    exp_cycles = 320;
    exp_page   = 8'hC0;
    model_copy(8'hC0, 160, 16'hFE00);
`endif
    check("retrig_busy_cycles", cycles, exp_cycles);
    check_region("retrig", 16'hFE00, 161);
    rd(16'hFF46, v);
    check("retrig_page", v, exp_page);

    // LEN=1, DST=FFFF instance: single byte 1200 -> FFFF
    b1 = 8'($urandom_range(0, 200));
    wr1(16'h1200, b1);
    wr1(16'h1201, 8'h77);
    wr1(16'hFFFF, 8'hEE);
    wr1(16'hFFFE, 8'hEE);
    wr1(16'h0000, 8'hEE);
    bus1.cpu_addr = 16'hFF46; bus1.cpu_we = 1'b1; bus1.cpu_wdata = 8'h12;
    @(negedge clock);
    bus1.cpu_we = 1'b0;
    #1;
    check("len1_rd_addr", bus1.mem_addr, 16'h1200);
    cycles = 0;
    while (dma_busy1 && cycles < 100) begin
      cycles++;
      @(negedge clock);
    end
    check("len1_busy_cycles", cycles, 2);
    check("len1_dst", mem1[16'hFFFF], b1);
    check("len1_guard_lo", mem1[16'hFFFE], 8'hEE);
    check("len1_guard_wrap", mem1[16'h0000], 8'hEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
# oam_dma_arbiter

Bus master arbiter that shares the single-port byte memory between the CPU and an OAM-style block-copy DMA engine. A CPU write to the DMA register copies `LEN` bytes from page `{page,8'h00}` to `DST`. The CPU is stalled while the copy runs. The block sits between the CPU memory port and the memory's address, enable and data lines.

## Interface
Parameters:
- `LEN`, 160: bytes per transfer; legal range 1..256.
- `DST`, 16'hFE00: destination base address.
- `REG_ADDR`, 16'hFF46: DMA trigger/page register address.

Ports:
- `clock` in 1: sole clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `cpu_addr` in 16: CPU address.
- `cpu_we` in 1: CPU write strobe.
- `cpu_re` in 1: CPU read strobe.
- `cpu_wdata` in 8: CPU write data.
- `cpu_rdata` out 8: CPU read data.
- `cpu_wait` out 1: CPU access not accepted this cycle; CPU holds request.
- `mem_addr` out 16: memory address.
- `mem_we` out 1: memory write enable.
- `mem_re` out 1: memory read enable.
- `mem_wdata` out 8: memory write data.
- `mem_rdata` in 8: memory read data; combinational, valid in same cycle as `mem_re`.
- `dma_busy` out 1: copy in progress.

## Operation
- States:
  - IDLE: CPU owns bus.
  - READ: DMA reads the source byte.
  - WRITE: DMA writes the destination byte.
- Registers:
  - `page[7:0]` holds the source page.
  - `cnt[8:0]` is the byte index.
  - `buf[7:0]` holds the byte in flight.
- IDLE, CPU access to any address other than `REG_ADDR`:
  - `mem_addr`/`mem_we`/`mem_re`/`mem_wdata` follow the CPU combinationally.
  - `cpu_rdata` = `mem_rdata`.
  - `cpu_wait` = 0.
- `REG_ADDR` access, any state:
  - Never forwarded to memory; never stalled.
  - A read returns `page`.
  - A write sets `page` = `cpu_wdata`, `cnt` = 0, next state READ.
  - Behaviour while busy depends on Configuration.
- READ:
  - `mem_addr` = `{page, cnt[7:0]}`, `mem_re` = 1.
  - At edge: `buf` <= `mem_rdata`, next state WRITE.
- WRITE:
  - `mem_addr` = `DST + cnt`, truncated to 16 bits (wraps at FFFF→0000).
  - `mem_we` = 1, `mem_wdata` = `buf`.
  - At edge: if `cnt` == `LEN-1`, go to IDLE; else `cnt` +1 and go to READ.
- READ/WRITE, CPU non-register access: `cpu_wait` = 1; CPU strobes not forwarded; `cpu_rdata` = 8'h00.
- `dma_busy` = 1 in READ and WRITE.
- Reset, including mid-copy:
  - Next state IDLE; `page`, `cnt`, `buf` = 0.
  - Memory keeps whatever was already copied.
- Reset outputs: `cpu_wait` 0, `dma_busy` 0, `mem_we` 0, `mem_re` 0. `cpu_rdata` and `mem_wdata` are 0 when no access is active.

## Timing
- Trigger write sampled at edge E0 → READ during cycle E0..E1. First source read is in that cycle.
- Each byte takes 2 cycles. A transfer occupies exactly `2*LEN` cycles: 320 at the default.
- `dma_busy` rises after E0 and falls after the edge closing the final WRITE.
- A CPU request stalled during the copy is serviced in the first IDLE cycle, with zero added latency after that.
- CPU data path is combinational in IDLE; there are no registered bubbles.

## Configuration
- `OAM_DMA_RESTART_EN`:
  - Defined: a `REG_ADDR` write while busy updates `page`, clears `cnt`, enters READ. The copy restarts from byte 0 of the new page; a pending `buf` is discarded.
  - Undefined: a `REG_ADDR` write while busy is ignored. `page` is unchanged, the copy continues, and `cpu_wait` stays 0 for that write.

## Structure
- Shared package `gbc_dma_pkg`: state enum (IDLE/READ/WRITE), default `LEN`/`DST`/`REG_ADDR` constants.
- Sub-module `oam_dma_seq`: FSM, `cnt`, `page`, `buf`, and DMA address generation.
- Top level `oam_dma_arbiter`: ownership mux, register decode, `cpu_wait`.

## Test plan
- Idle passthrough: CPU write 8'hA5 to 16'hC000, then read → `mem_we` 1 at C000, read returns A5, `cpu_wait` 0 throughout.
- Full copy: preload C000..C09F with `i^8'h5A`, write 8'hC0 to FF46 → `dma_busy` high for exactly 320 cycles; FE00..FE9F match the source; FF46 reads back C0.
- Stall: CPU read of 16'hC010 issued 5 cycles into the copy → `cpu_wait` 1 until `dma_busy` falls; data returned in the first IDLE cycle.
- Reset mid-copy at byte 40 → outputs zero next cycle; FE00..FE27 written, FE28 untouched (8'hEE preload).
- Re-trigger at byte 10 with page D0 → with `OAM_DMA_RESTART_EN`, busy lasts 20+320 cycles and the destination holds D0xx data; without it, busy lasts 320 cycles and the destination holds C0xx data.
- `LEN`=1, `DST`=16'hFFFF, page 8'h12 → single byte 1200 copied to FFFF, busy for 2 cycles.
